// File: rtl/step_watchdog.sv
// step_watchdog
//   Idle-time monitor for the stepper step/dir outputs. Each channel has an
//   idle counter that saturates at TIMEOUT = HZ*TIMEOUT_S and raises a
//   registered alert. The endstop pin (arm_n, active-low, asynchronous) arms
//   the watchdog. Once armed, an alert on channel WATCH_CH latches a sticky
//   shutdown request. Only clear or rst release that request.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   step, dir     per-channel step/dir from the command block (clk domain)
//   arm_n         asynchronous arm pin, low arms the watchdog
//   clear         one-cycle pulse: leave TRIPPED and restart the idle timers
//   alert         per-channel idle-timeout flag
//   armed         state is ARMED or TRIPPED
//   req_shutdown  state is TRIPPED (sticky)
//   idle_msb      top 8 bits of the watched channel's idle counter (debug)
//   pos           signed per-channel step positions (STEPWATCH_POSITION_EN only)
//
// Build option
//   STEPWATCH_POSITION_EN  adds per-channel position counters and the pos port.
//
// state       | meaning
// ------------+------------------------------------------------
// ST_DISARMED | watching idle time only, no shutdown possible
// ST_ARMED    | endstop seen, alert on WATCH_CH trips shutdown
// ST_TRIPPED  | shutdown requested, held until clear or rst
module step_watchdog #(
  parameter int NSTEPDIR  = 6,
  parameter int HZ        = 48000000,
  parameter int TIMEOUT_S = 10,
  parameter int CNT_BITS  = 32,
  parameter int WATCH_CH  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NSTEPDIR-1:0]          step,
  input  logic [NSTEPDIR-1:0]          dir,
  input  logic                         arm_n,
  input  logic                         clear,
  output logic [NSTEPDIR-1:0]          alert,
  output logic                         armed,
  output logic                         req_shutdown,
  output logic [7:0]                   idle_msb
`ifdef STEPWATCH_POSITION_EN
  ,
  output logic [NSTEPDIR*CNT_BITS-1:0] pos
`endif
);

  localparam longint TIMEOUT_L = longint'(HZ) * longint'(TIMEOUT_S);
  localparam logic [CNT_BITS-1:0] TIMEOUT = CNT_BITS'(TIMEOUT_L);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRIPPED  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                arm_meta_q, arm_s_q;
  logic [NSTEPDIR-1:0] prev_step_q, prev_step_d;
  logic [NSTEPDIR-1:0] edge_det;
  logic [NSTEPDIR-1:0] alert_q, alert_d;
  logic [CNT_BITS-1:0] idle_cnt_q [NSTEPDIR];
  logic [CNT_BITS-1:0] idle_cnt_d [NSTEPDIR];
  logic                armed_q, armed_d;
  logic                req_q, req_d;
  logic [7:0]          idle_msb_q, idle_msb_d;

  // Idle timers: any step edge (either polarity) or clear restarts a channel.
  // An edge in the cycle the counter sits at TIMEOUT suppresses the alert.
  always_comb begin
    edge_det    = step ^ prev_step_q;
    prev_step_d = step;
    alert_d     = '0;
    for (int i = 0; i < NSTEPDIR; i++) begin
      idle_cnt_d[i] = idle_cnt_q[i];
      if (clear || edge_det[i]) begin
        idle_cnt_d[i] = '0;
      end else if (idle_cnt_q[i] != TIMEOUT) begin
        idle_cnt_d[i] = idle_cnt_q[i] + CNT_BITS'(1);
      end
      // clear drops alerts together with the counters so the cycle after
      // clear reads back all-quiet.
      alert_d[i] = !clear && !edge_det[i] && (idle_cnt_q[i] == TIMEOUT);
    end
    idle_msb_d = idle_cnt_q[WATCH_CH][CNT_BITS-1 -: 8];
  end

  // clear takes priority over a trip arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DISARMED: if (!clear && !arm_s_q) state_d = ST_ARMED;
      ST_ARMED:    if (alert_q[WATCH_CH]) state_d = clear ? ST_DISARMED : ST_TRIPPED;
      ST_TRIPPED:  if (clear) state_d = ST_DISARMED;
      default:     state_d = ST_DISARMED;
    endcase
    armed_d = (state_d != ST_DISARMED);
    req_d   = (state_d == ST_TRIPPED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DISARMED;
      arm_meta_q  <= 1'b1;
      arm_s_q     <= 1'b1;
      prev_step_q <= '0;
      alert_q     <= '0;
      armed_q     <= 1'b0;
      req_q       <= 1'b0;
      idle_msb_q  <= '0;
      for (int i = 0; i < NSTEPDIR; i++) idle_cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      arm_meta_q  <= arm_n;
      arm_s_q     <= arm_meta_q;
      prev_step_q <= prev_step_d;
      alert_q     <= alert_d;
      armed_q     <= armed_d;
      req_q       <= req_d;
      idle_msb_q  <= idle_msb_d;
      for (int i = 0; i < NSTEPDIR; i++) idle_cnt_q[i] <= idle_cnt_d[i];
    end
  end

  assign alert        = alert_q;
  assign armed        = armed_q;
  assign req_shutdown = req_q;
  assign idle_msb     = idle_msb_q;

`ifdef STEPWATCH_POSITION_EN
  logic [CNT_BITS-1:0] pos_q [NSTEPDIR];
  logic [CNT_BITS-1:0] pos_d [NSTEPDIR];
  logic [NSTEPDIR-1:0] rise;

  // Only rising step edges move the position; the counter wraps freely and
  // is deliberately left alone by clear.
  always_comb begin
    rise = step & ~prev_step_q;
    for (int i = 0; i < NSTEPDIR; i++) begin
      pos_d[i] = pos_q[i];
      if (rise[i]) pos_d[i] = dir[i] ? pos_q[i] + CNT_BITS'(1) : pos_q[i] - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSTEPDIR; i++) pos_q[i] <= '0;
    end else begin
      for (int i = 0; i < NSTEPDIR; i++) pos_q[i] <= pos_d[i];
    end
  end

  for (genvar g = 0; g < NSTEPDIR; g++) begin : g_pos
    assign pos[g*CNT_BITS +: CNT_BITS] = pos_q[g];
  end
`else
  logic unused_dir;
  assign unused_dir = ^dir;
`endif

endmodule

// File: tb/tb_step_watchdog.sv
module tb_step_watchdog;
  localparam int N   = 6;
  localparam int CB  = 32;
  localparam int WCH = 5;
  localparam int TO  = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  step, dir;
  logic          arm_n, clear;
  logic [N-1:0]  alert;
  logic          armed, req_shutdown;
  logic [7:0]    idle_msb;
`ifdef STEPWATCH_POSITION_EN
  logic [N*CB-1:0] pos;
`endif

  step_watchdog #(
    .NSTEPDIR(N), .HZ(100), .TIMEOUT_S(1), .CNT_BITS(CB), .WATCH_CH(WCH)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .arm_n(arm_n), .clear(clear),
    .alert(alert), .armed(armed), .req_shutdown(req_shutdown), .idle_msb(idle_msb)
`ifdef STEPWATCH_POSITION_EN
    , .pos(pos)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timestamp of the last restart event per channel,
  // output flags derived from elapsed cycles.
  int          cyc = 0;
  int          last_act [N];
  logic [N-1:0] prev_m = '0;
  logic [N-1:0] alert_m = '0;
  logic        s1_m = 1'b1, s2_m = 1'b1;
  logic        armed_m = 1'b0, trip_m = 1'b0;
  logic [7:0]  msb_m = '0;
  logic [31:0] pos_m [N];
  bit          started = 0;

  initial for (int i = 0; i < N; i++) begin
    last_act[i] = 0;
    pos_m[i] = '0;
  end

  always @(posedge clk) begin
    logic [N-1:0] e;
    logic         trip_in, arm_in, act;
    int           d;
    logic [31:0]  v;
    e       = step ^ prev_m;
    trip_in = alert_m[WCH];
    arm_in  = s2_m;

    d = cyc - 1 - last_act[WCH];
    v = (d >= TO) ? 32'(TO) : 32'(d);
    msb_m = rst ? 8'h00 : v[31:24];

    for (int i = 0; i < N; i++) begin
      act = rst | clear | e[i];
      d = cyc - 1 - last_act[i];
      alert_m[i] = !act && (d >= TO);
      if (act) last_act[i] = cyc;
    end

    if (rst) begin
      armed_m = 1'b0; trip_m = 1'b0;
    end else if (clear) begin
      if (trip_m || (armed_m && trip_in)) begin armed_m = 1'b0; trip_m = 1'b0; end
    end else if (!armed_m) begin
      if (!arm_in) armed_m = 1'b1;
    end else if (!trip_m && trip_in) begin
      trip_m = 1'b1;
    end

    s2_m = rst ? 1'b1 : s1_m;
    s1_m = rst ? 1'b1 : arm_n;

    for (int i = 0; i < N; i++) begin
      if (rst) pos_m[i] = '0;
      else if (step[i] && !prev_m[i]) pos_m[i] = dir[i] ? pos_m[i] + 32'd1 : pos_m[i] - 32'd1;
    end
    prev_m = rst ? '0 : step;
    cyc++;
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("alert", alert, alert_m);
      check("armed", armed, armed_m);
      check("req_shutdown", req_shutdown, trip_m);
      check("idle_msb", idle_msb, msb_m);
`ifdef STEPWATCH_POSITION_EN
      for (int i = 0; i < N; i++) check("pos", pos[i*CB +: CB], pos_m[i]);
`endif
    end
  end

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    bit seen;
    int rate [N] = '{30, 80, 150, 300, 60, 220};
    rst = 1'b1; clear = 1'b0; arm_n = 1'b1; step = '0; dir = '0;

    // 1: reset and free-running timers
    step_n(3);
    rst = 1'b0;
    check("s1_alert_rst", alert, 0);
    check("s1_armed_rst", armed, 0);
    check("s1_req_rst", req_shutdown, 0);
    check("s1_msb_rst", idle_msb, 0);
    step_n(100);
    check("s1_alert_100", alert, 0);
    step_n(1);
    check("s1_alert_101", alert, 6'h3F);
    check("s1_req", req_shutdown, 0);

    // 2: periodic activity on ch2 keeps it quiet
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step[2] = ~step[2];
      for (int c = 0; c < 50; c++) begin
        step_n(1);
        if (alert[2]) bad++;
      end
    end
    check("s2_no_alert", bad, 0);
    step[2] = ~step[2];
    step_n(101);
    check("s2_alert_100", alert[2], 0);
    step_n(1);
    check("s2_alert_101", alert[2], 1);

    // 3: arm, trip on idle ch5, stays tripped through activity
    rst = 1'b1; step_n(1); rst = 1'b0;
    step_n(9);
    arm_n = 1'b0; step_n(1); arm_n = 1'b1;
    check("s3_armed_c11", armed, 0);
    step_n(1);
    check("s3_armed_c12", armed, 0);
    step_n(1);
    check("s3_armed_c13", armed, 1);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step_n(1);
      if (alert[5]) seen = 1;
    end
    check("s3_alert5_seen", seen, 1);
    check("s3_req_with_alert", req_shutdown, 0);
    step_n(1);
    check("s3_req_after_alert", req_shutdown, 1);
    for (int k = 0; k < 5; k++) begin
      step[5] = ~step[5];
      step_n(3);
    end
    check("s3_req_sticky", req_shutdown, 1);

    // 4: clear from TRIPPED, then clear racing a trip
    clear = 1'b1; step_n(1); clear = 1'b0;
    check("s4_req_clr", req_shutdown, 0);
    check("s4_armed_clr", armed, 0);
    check("s4_alert_clr", alert, 0);
    step_n(100);
    check("s4_alert_100", alert, 0);
    step_n(1);
    check("s4_alert_101", alert, 6'h3F);
    clear = 1'b1; arm_n = 1'b0; step_n(1); clear = 1'b0; arm_n = 1'b1;
    step_n(2);
    check("s4_rearmed", armed, 1);
    step_n(99);
    check("s4_alert5_up", alert[5], 1);
    check("s4_req_before", req_shutdown, 0);
    clear = 1'b1; step_n(1); clear = 1'b0;
    check("s4_race_armed", armed, 0);
    check("s4_race_req", req_shutdown, 0);
    check("s4_race_alert", alert, 0);
    step_n(1);
    check("s4_race_req2", req_shutdown, 0);

    // 5: edge exactly at saturation suppresses the alert
    clear = 1'b1; step_n(1); clear = 1'b0;
    step_n(100);
    step[0] = ~step[0];
    step_n(1);
    check("s5_alert0", alert[0], 0);
    check("s5_alert1", alert[1], 1);
    step_n(100);
    check("s5_alert0_100", alert[0], 0);
    step_n(1);
    check("s5_alert0_101", alert[0], 1);

    // 6: position tracking on ch1
    rst = 1'b1; step_n(1); rst = 1'b0;
    dir[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step[1] = 1'b1; step_n(1); step[1] = 1'b0; step_n(1);
    end
    dir[1] = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step[1] = 1'b1; step_n(1); step[1] = 1'b0; step_n(1);
    end
`ifdef STEPWATCH_POSITION_EN
    check("s6_pos1", pos[1*CB +: CB], 32'hFFFF_FFFD);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, rate[i]) == 0) step[i] = ~step[i];
      dir   = N'($urandom);
      clear = ($urandom_range(0, 399) == 0);
      arm_n = ($urandom_range(0, 149) != 0);
      rst   = ($urandom_range(0, 1999) == 0);
      step_n(1);
    end
    rst = 1'b0; clear = 1'b0; arm_n = 1'b1;
    step_n(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
